// File: rtl/arduino_spi_target.sv
// arduino_spi_target: SPI mode-0 target oversampled in the clk domain.
// Deserialises MOSI into words and serialises TX words onto MISO through a valid/ready load.
module arduino_spi_target #(
  parameter int                DATA_W    = 8,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] TX_IDLE   = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sclk_s,
  input  logic              mosi_s,
  input  logic              cs_n_s,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic              frame_err_o
);

  // state  | meaning
  // ARMED  | out of reset; waits for CS_N high so a frame already in flight is ignored
  // IDLE   | between frames; CS_N falling edge starts a frame and loads the first TX word
  // ACTIVE | frame in progress; rises sample MOSI, falls advance or reload MISO
  typedef enum logic [1:0] {ARMED, IDLE, ACTIVE} state_t;

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic                sclk_q, cs_q;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_rx_q, shreg_rx_d;
  logic [DATA_W-1:0]   shreg_tx_q, shreg_tx_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                underrun_q, underrun_d;
  logic                frame_err_q, frame_err_d;
  logic                load_pend_q, load_pend_d;
  logic                started_q, started_d;

  logic                rise, fall, cs_fall, do_load;
  logic [DATA_W-1:0]   rx_shift, tx_shift, load_word;

  assign rise    = sclk_s & ~sclk_q;
  assign fall    = ~sclk_s & sclk_q;
  assign cs_fall = ~cs_n_s & cs_q;

  assign rx_shift  = MSB_FIRST ? {shreg_rx_q[DATA_W-2:0], mosi_s} : {mosi_s, shreg_rx_q[DATA_W-1:1]};
  assign tx_shift  = MSB_FIRST ? {shreg_tx_q[DATA_W-2:0], 1'b0}   : {1'b0, shreg_tx_q[DATA_W-1:1]};
  assign load_word = tx_valid_i ? tx_data_i : TX_IDLE;

  // A load happens at frame start, or on the first fall after a word completes.
  assign do_load = ((state_q == IDLE) & cs_fall) |
                   ((state_q == ACTIVE) & ~cs_n_s & fall & load_pend_q);

  assign tx_ready_o    = do_load & tx_valid_i;
  assign tx_underrun_o = underrun_q;
  assign frame_err_o   = frame_err_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign miso_oe_o     = (state_q == ACTIVE);
  assign miso_o        = (state_q == ACTIVE) &
                         (MSB_FIRST ? shreg_tx_q[DATA_W-1] : shreg_tx_q[0]);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_rx_d  = shreg_rx_q;
    shreg_tx_d  = shreg_tx_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    load_pend_d = load_pend_q;
    started_d   = started_q;

    if (do_load) begin
      shreg_tx_d  = load_word;
      underrun_d  = ~tx_valid_i;
      load_pend_d = 1'b0;
    end

    case (state_q)
      ARMED: begin
        if (cs_n_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          started_d = 1'b0;
        end
      end
      ACTIVE: begin
        // CS_N high takes priority over any SCLK edge seen in the same cycle.
        if (cs_n_s) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
        end else if (rise) begin
          shreg_rx_d = rx_shift;
          started_d  = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d   = '0;
            rx_data_d   = rx_shift;
            rx_valid_d  = 1'b1;
            load_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (fall && started_q && !load_pend_q) begin
          shreg_tx_d = tx_shift;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ARMED;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      bit_cnt_q   <= '0;
      shreg_rx_q  <= '0;
      shreg_tx_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      load_pend_q <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_s;
      cs_q        <= cs_n_s;
      bit_cnt_q   <= bit_cnt_d;
      shreg_rx_q  <= shreg_rx_d;
      shreg_tx_q  <= shreg_tx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      load_pend_q <= load_pend_d;
      started_q   <= started_d;
    end
  end

endmodule

// File: tb/tb_arduino_spi_target.sv
// Bench for arduino_spi_target: an 8-bit MSB-first instance and a 16-bit LSB-first instance,
// driven by a bit-banged SPI master and checked against expected-word queues.
module tb_arduino_spi_target;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        sclk8 = 1'b0, mosi8 = 1'b0, cs8 = 1'b1;
  logic        miso8, oe8, rxv8, rdy8, und8, ferr8;
  logic [7:0]  rxd8;
  logic [7:0]  txd8 = 8'h00;
  logic        txv8 = 1'b0;

  logic        sclk16 = 1'b0, mosi16 = 1'b0, cs16 = 1'b1;
  logic        miso16, oe16, rxv16, rdy16, und16, ferr16;
  logic [15:0] rxd16;
  logic [15:0] txd16 = 16'hC3A5;
  logic        txv16 = 1'b1;

  arduino_spi_target #(.DATA_W(8), .MSB_FIRST(1'b1), .TX_IDLE(8'hFF)) u_dut8 (
    .clk(clk), .rstn(rstn), .sclk_s(sclk8), .mosi_s(mosi8), .cs_n_s(cs8),
    .miso_o(miso8), .miso_oe_o(oe8), .rx_data_o(rxd8), .rx_valid_o(rxv8),
    .tx_data_i(txd8), .tx_valid_i(txv8), .tx_ready_o(rdy8),
    .tx_underrun_o(und8), .frame_err_o(ferr8));

  arduino_spi_target #(.DATA_W(16), .MSB_FIRST(1'b0), .TX_IDLE(16'hFFFF)) u_dut16 (
    .clk(clk), .rstn(rstn), .sclk_s(sclk16), .mosi_s(mosi16), .cs_n_s(cs16),
    .miso_o(miso16), .miso_oe_o(oe16), .rx_data_o(rxd16), .rx_valid_o(rxv16),
    .tx_data_i(txd16), .tx_valid_i(txv16), .tx_ready_o(rdy16),
    .tx_underrun_o(und16), .frame_err_o(ferr16));

  int total = 0;
  int bad = 0;

  logic [7:0] offer_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  int rx_cnt = 0, rdy_cnt = 0, und_cnt = 0, ferr_cnt = 0, rx16_cnt = 0;
  logic [15:0] rx16_last = 16'h0;
  logic pop_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Monitor samples mid-cycle; the TX offer is advanced just after the accepting edge.
  always begin
    @(negedge clk);
    if (rxv8) begin
      rx_cnt++;
      if (exp_rx.size() == 0) chk("rx_unexp", rxv8, 0);
      else chk("rx_data", rxd8, exp_rx.pop_front());
    end
    if (rdy8) begin
      rdy_cnt++;
      exp_miso.push_back(txd8);
      pop_req = 1'b1;
    end
    if (und8) begin
      und_cnt++;
      exp_miso.push_back(8'hFF);
    end
    if (ferr8) ferr_cnt++;
    if (rxv16) begin
      rx16_cnt++;
      rx16_last = rxd16;
    end
    @(posedge clk);
    #1;
    if (pop_req && offer_q.size() > 0) void'(offer_q.pop_front());
    pop_req = 1'b0;
    txv8 = (offer_q.size() > 0);
    txd8 = txv8 ? offer_q[0] : 8'h00;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_word(input bit sel, input int nbits, input bit msb,
                          input logic [31:0] mo, output logic [31:0] mi);
    int idx;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? nbits - 1 - i : i;
      if (sel) mosi16 = mo[idx]; else mosi8 = mo[idx];
      tick(HALF);
      mi[idx] = sel ? miso16 : miso8;
      if (sel) sclk16 = 1'b1; else sclk8 = 1'b1;
      tick(HALF);
      if (sel) sclk16 = 1'b0; else sclk8 = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic word8(input logic [7:0] mo, input string tag);
    logic [31:0] mi;
    logic [7:0]  e;
    exp_rx.push_back(mo);
    spi_word(1'b0, 8, 1'b1, {24'h0, mo}, mi);
    e = (exp_miso.size() > 0) ? exp_miso.pop_front() : 8'hxx;
    chk(tag, mi, {24'h0, e});
  endtask

  task automatic cs8_low();
    exp_miso.delete();
    cs8 = 1'b0;
    tick(1);
  endtask

  task automatic cs8_high();
    cs8 = 1'b1;
    tick(HALF);
  endtask

  int r0, d0, u0, f0;
  task automatic snap();
    r0 = rx_cnt; d0 = rdy_cnt; u0 = und_cnt; f0 = ferr_cnt;
  endtask

  initial begin
    logic [31:0] mi;
    tick(3);
    chk("rst_oe", oe8, 0);
    chk("rst_miso", miso8, 0);
    chk("rst_rxv", rxv8, 0);
    chk("rst_rxd", rxd8, 0);
    chk("rst_flags", {rdy8, und8, ferr8}, 0);
    chk("rst_u16", {oe16, miso16, rxv16, rdy16, und16, ferr16, rxd16}, 0);
    rstn = 1'b1;
    tick(4);

    // 1: single word, TX A5 held
    offer_q.push_back(8'hA5); offer_q.push_back(8'hA5);
    tick(3);
    snap();
    cs8_low();
    chk("t1_oe", oe8, 1);
    chk("t1_rdy_csfall", rdy_cnt - d0, 1);
    word8(8'h3C, "t1_miso");
    cs8_high();
    chk("t1_rx_cnt", rx_cnt - r0, 1);
    chk("t1_rdy_cnt", rdy_cnt - d0, 2);
    chk("t1_und", und_cnt - u0, 0);
    chk("t1_oe_off", oe8, 0);

    // 2: 3-word burst
    offer_q.push_back(8'h11); offer_q.push_back(8'h22); offer_q.push_back(8'h33);
    tick(3);
    snap();
    cs8_low();
    word8(8'h01, "t2_miso0");
    word8(8'h02, "t2_miso1");
    word8(8'h03, "t2_miso2");
    cs8_high();
    chk("t2_rx_cnt", rx_cnt - r0, 3);
    chk("t2_rdy_cnt", rdy_cnt - d0, 3);
    chk("t2_und", und_cnt - u0, 1);
    chk("t2_ferr", ferr_cnt - f0, 0);

    // 3: underrun at frame start
    tick(3);
    snap();
    cs8_low();
    word8(8'h5A, "t3_miso");
    cs8_high();
    chk("t3_und", und_cnt - u0, 2);
    chk("t3_rdy", rdy_cnt - d0, 0);
    chk("t3_rx_cnt", rx_cnt - r0, 1);

    // 4: partial frame then a clean frame
    snap();
    cs8_low();
    spi_word(1'b0, 5, 1'b1, 32'h15, mi);
    cs8_high();
    chk("t4_ferr", ferr_cnt - f0, 1);
    chk("t4_no_rx", rx_cnt - r0, 0);
    offer_q.push_back(8'h96);
    tick(3);
    snap();
    cs8_low();
    word8(8'hC3, "t4_miso");
    cs8_high();
    chk("t4_rx_cnt", rx_cnt - r0, 1);
    chk("t4_ferr2", ferr_cnt - f0, 0);

    // 5: reset released mid-frame
    rstn = 1'b0;
    cs8 = 1'b0;
    tick(3);
    chk("t5_rst_rxd", rxd8, 0);
    rstn = 1'b1;
    tick(2);
    snap();
    spi_word(1'b0, 4, 1'b1, 32'hF, mi);
    chk("t5_no_rx", rx_cnt - r0, 0);
    chk("t5_oe", oe8, 0);
    chk("t5_miso", miso8, 0);
    chk("t5_rdy", rdy_cnt - d0, 0);
    cs8_high();
    chk("t5_ferr", ferr_cnt - f0, 0);
    offer_q.push_back(8'h77);
    tick(3);
    snap();
    cs8_low();
    word8(8'hE1, "t5_miso_after");
    cs8_high();
    chk("t5_rx_cnt", rx_cnt - r0, 1);

    // 6: 16-bit LSB-first instance
    cs16 = 1'b0;
    tick(1);
    spi_word(1'b1, 16, 1'b0, 32'h8001, mi);
    chk("t6_miso0", mi, 32'hC3A5);
    chk("t6_rx_cnt1", rx16_cnt, 1);
    chk("t6_rx_data0", rx16_last, 16'h8001);
    spi_word(1'b1, 16, 1'b0, 32'h1234, mi);
    chk("t6_miso1", mi, 32'hC3A5);
    chk("t6_rx_cnt2", rx16_cnt, 2);
    chk("t6_rx_data1", rx16_last, 16'h1234);
    cs16 = 1'b1;
    tick(HALF);

    chk("rx_left", exp_rx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
